// File: rtl/time_set_controller.sv
`default_nettype none
// ============================================================================
// Module      : time_set_controller
// Description : Time-setting controller for the clock display path.
//               Selects live time or the edit buffer for display, produces
//               the per-field flash vector and the 12/24-hour display mode,
//               runs the four-button edit state machine with auto-repeat
//               and inactivity timeout, and issues a one-cycle load strobe
//               to the time counter when an edit is committed.
//
// Ports       : clk          - system clock
//               rst_n        - asynchronous, active-low reset
//               btn_mode     - raw level; 12/24 toggle in RUN, abort in SET
//               btn_next     - raw level; enter edit / next field / commit
//               btn_up       - raw level; increment selected field
//               btn_down     - raw level; decrement selected field
//               cur_time     - live time {hour[20:14], min[13:7], sec[6:0]}
//               out_time     - time shown on the display
//               flash        - blink enable, [2]=hour [1]=min [0]=sec
//               display_mode - 0 = 24-hour, 1 = 12-hour
//               load         - one-cycle commit strobe
//               load_time    - value to load, valid while load = 1
//
// Revision    : 1.0 - initial release
// ============================================================================
module time_set_controller #(
   parameter int REPEAT_DELAY = 25000000,
   parameter int REPEAT_RATE  = 5000000,
   parameter int TIMEOUT      = 500000000,
   parameter int CNT_W        = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        btn_mode,
   input  logic        btn_next,
   input  logic        btn_up,
   input  logic        btn_down,
   input  logic [20:0] cur_time,
   output logic [20:0] out_time,
   output logic [2:0]  flash,
   output logic        display_mode,
   output logic        load,
   output logic [20:0] load_time
);

   // Bit positions of the buttons inside the conditioned button vectors.
   localparam int c_b_mode = 3;
   localparam int c_b_next = 2;
   localparam int c_b_up   = 1;
   localparam int c_b_down = 0;

   // Repeat counter landmarks. The counter holds at 1 on the press edge,
   // reaches c_delay REPEAT_DELAY cycles later (second step), then cycles
   // between c_delay_p1 and c_rate_end so a step fires every REPEAT_RATE.
   localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);
   localparam logic [CNT_W-1:0] c_delay    = CNT_W'(REPEAT_DELAY);
   localparam logic [CNT_W-1:0] c_delay_p1 = CNT_W'(REPEAT_DELAY + 1);
   localparam logic [CNT_W-1:0] c_rate_end = CNT_W'(REPEAT_DELAY + REPEAT_RATE);
   localparam logic [CNT_W-1:0] c_to_last  = CNT_W'(TIMEOUT - 1);

   localparam logic [6:0] c_hour_max = 7'd24;
   localparam logic [6:0] c_ms_max   = 7'd60;

   typedef enum logic [1:0] {
      S_RUN  = 2'd0,
      S_HOUR = 2'd1,
      S_MIN  = 2'd2,
      S_SEC  = 2'd3
   } state_t;

   // ------------------------------------------------------------------------
   // Field arithmetic. Out-of-range captured values (e.g. minute 75) wrap to
   // 0 on increment and clamp to the maximum on decrement.
   // ------------------------------------------------------------------------
   function automatic logic [6:0] f_inc(input logic [6:0] v, input logic [6:0] m);
      return (v >= m - 7'd1) ? 7'd0 : v + 7'd1;
   endfunction

   function automatic logic [6:0] f_dec(input logic [6:0] v, input logic [6:0] m);
      return ((v == 7'd0) || (v > m - 7'd1)) ? m - 7'd1 : v - 7'd1;
   endfunction

   function automatic logic [2:0] f_flash(input state_t s);
      logic [2:0] f;
      case (s)
         S_HOUR:  f = 3'b100;
         S_MIN:   f = 3'b010;
         S_SEC:   f = 3'b001;
         default: f = 3'b000;
      endcase
      return f;
   endfunction

   // ------------------------------------------------------------------------
   // Signals
   // ------------------------------------------------------------------------
   state_t           r_state;
   state_t           w_next_state;

   logic [3:0]       w_btn_raw;
   logic [3:0]       r_sync1;
   logic [3:0]       r_sync2;
   logic [3:0]       r_sync3;
   logic [3:0]       w_rise;
   logic             w_any_rise;

   logic [20:0]      r_edit;
   logic [20:0]      w_next_edit;
   logic [6:0]       w_field;
   logic [6:0]       w_field_max;

   logic [CNT_W-1:0] r_rpt;
   logic [CNT_W-1:0] r_to;

   logic             w_set;
   logic             w_one_held;
   logic             w_updown_rise;
   logic             w_rpt_fire;
   logic             w_up_step;
   logic             w_dn_step;
   logic             w_timeout;
   logic             w_state_change;
   logic             w_commit;
   logic             w_toggle_mode;

   logic [2:0]       r_flash;
   logic             r_display_mode;
   logic             r_load;
   logic [20:0]      r_load_time;

   // ------------------------------------------------------------------------
   // Input conditioning: 2-FF synchronizer plus one delay stage for rising
   // edge detection. r_sync2 is the synchronized level used for auto-repeat.
   // ------------------------------------------------------------------------
   assign w_btn_raw  = {btn_mode, btn_next, btn_up, btn_down};
   assign w_rise     = r_sync2 & ~r_sync3;
   assign w_any_rise = |w_rise;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_sync3 <= '0;
      end else begin
         r_sync1 <= w_btn_raw;
         r_sync2 <= r_sync1;
         r_sync3 <= r_sync2;
      end
   end

   // ------------------------------------------------------------------------
   // Step qualification. Exactly one of up/down must be held; holding both
   // suppresses all stepping. A repeat step never coincides with a press
   // edge because the edge itself is the first step.
   // ------------------------------------------------------------------------
   assign w_set         = (r_state != S_RUN);
   assign w_one_held    = r_sync2[c_b_up] ^ r_sync2[c_b_down];
   assign w_updown_rise = w_rise[c_b_up] | w_rise[c_b_down];
   assign w_rpt_fire    = w_set & w_one_held & ~w_updown_rise &
                          ((r_rpt == c_delay) || (r_rpt == c_rate_end));
   assign w_up_step     = (w_rise[c_b_up] | w_rpt_fire) &
                          r_sync2[c_b_up] & ~r_sync2[c_b_down];
   assign w_dn_step     = (w_rise[c_b_down] | w_rpt_fire) &
                          r_sync2[c_b_down] & ~r_sync2[c_b_up];

   // Timeout only fires on an idle cycle; any edge would have cleared it.
   assign w_timeout      = w_set & (r_to == c_to_last) & ~w_any_rise;
   assign w_state_change = (w_next_state != r_state);

   // Currently selected field and its modulus.
   always_comb begin
      w_field     = r_edit[6:0];
      w_field_max = c_ms_max;
      case (r_state)
         S_HOUR: begin
            w_field     = r_edit[20:14];
            w_field_max = c_hour_max;
         end
         S_MIN:   w_field = r_edit[13:7];
         default: w_field = r_edit[6:0];
      endcase
   end

   // ------------------------------------------------------------------------
   // Next-state and edit-buffer logic. Priority: mode > next > up/down.
   // ------------------------------------------------------------------------
   always_comb begin
      w_next_state  = r_state;
      w_next_edit   = r_edit;
      w_commit      = 1'b0;
      w_toggle_mode = 1'b0;

      if (r_state == S_RUN) begin
         if (w_rise[c_b_mode]) begin
            w_toggle_mode = 1'b1;
         end else if (w_rise[c_b_next]) begin
            // Snapshot live time; later cur_time changes do not reach edit.
            w_next_edit  = cur_time;
            w_next_state = S_HOUR;
         end
      end else begin
         if (w_rise[c_b_mode] || w_timeout) begin
            w_next_state = S_RUN;
         end else if (w_rise[c_b_next]) begin
            case (r_state)
               S_HOUR:  w_next_state = S_MIN;
               S_MIN:   w_next_state = S_SEC;
               default: begin
                  w_next_state = S_RUN;
                  w_commit     = 1'b1;
               end
            endcase
         end else if (w_up_step || w_dn_step) begin
            case (r_state)
               S_HOUR:  w_next_edit[20:14] = w_up_step ? f_inc(w_field, w_field_max)
                                                        : f_dec(w_field, w_field_max);
               S_MIN:   w_next_edit[13:7]  = w_up_step ? f_inc(w_field, w_field_max)
                                                        : f_dec(w_field, w_field_max);
               default: w_next_edit[6:0]   = w_up_step ? f_inc(w_field, w_field_max)
                                                        : f_dec(w_field, w_field_max);
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_RUN;
      end else begin
         r_state <= w_next_state;
      end
   end

   // ------------------------------------------------------------------------
   // Auto-repeat and inactivity counters.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rpt <= '0;
      end else if (!w_set || !w_one_held || w_state_change) begin
         r_rpt <= '0;
      end else if (w_updown_rise) begin
         r_rpt <= c_one;
      end else if (r_rpt == c_rate_end) begin
         r_rpt <= c_delay_p1;
      end else begin
         r_rpt <= r_rpt + c_one;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_to <= '0;
      end else if (w_any_rise || w_state_change || !w_set) begin
         r_to <= '0;
      end else begin
         r_to <= r_to + c_one;
      end
   end

   // ------------------------------------------------------------------------
   // Edit buffer and registered outputs.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_edit         <= '0;
         r_flash        <= 3'b000;
         r_display_mode <= 1'b0;
         r_load         <= 1'b0;
         r_load_time    <= '0;
      end else begin
         r_edit  <= w_next_edit;
         r_flash <= f_flash(w_next_state);
         r_load  <= w_commit;
         if (w_toggle_mode) begin
            r_display_mode <= ~r_display_mode;
         end
         if (w_commit) begin
            r_load_time <= r_edit;
         end
      end
   end

   assign out_time     = (r_state == S_RUN) ? cur_time : r_edit;
   assign flash        = r_flash;
   assign display_mode = r_display_mode;
   assign load         = r_load;
   assign load_time    = r_load_time;

endmodule
`default_nettype wire

// File: tb/tb_time_set_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_time_set_controller
// Description : Self-checking bench for time_set_controller. Scenario tasks
//               drive buttons and compare outputs inline; committed values
//               are queued and matched against each load pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_time_set_controller;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        btn_mode = 1'b0;
   logic        btn_next = 1'b0;
   logic        btn_up = 1'b0;
   logic        btn_down = 1'b0;
   logic [20:0] cur_time = '0;
   logic [20:0] out_time;
   logic [2:0]  flash;
   logic        display_mode;
   logic        load;
   logic [20:0] load_time;

   int          n_checks = 0;
   int          n_fail = 0;
   logic [20:0] exp_q[$];
   logic [20:0] exp_load;
   logic        prev_load = 1'b0;

   time_set_controller #(
      .REPEAT_DELAY(8),
      .REPEAT_RATE (4),
      .TIMEOUT     (64),
      .CNT_W       (32)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .btn_mode    (btn_mode),
      .btn_next    (btn_next),
      .btn_up      (btn_up),
      .btn_down    (btn_down),
      .cur_time    (cur_time),
      .out_time    (out_time),
      .flash       (flash),
      .display_mode(display_mode),
      .load        (load),
      .load_time   (load_time)
   );

   always #5 clk = ~clk;

   // Load scoreboard: every load pulse must match a queued commit value and
   // last exactly one cycle.
   always @(negedge clk) begin
      if (load) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_load: load_time=%h, required no load", load_time);
         end else begin
            exp_load = exp_q.pop_front();
            if (load_time !== exp_load) begin
               n_fail++;
               $display("FAIL load_time: got %h, required %h", load_time, exp_load);
            end
         end
         if (prev_load) begin
            n_fail++;
            $display("FAIL load_width: load high for more than one cycle");
         end
      end
      prev_load = load;
   end

   // One-cycle press of {mode,next,up,down}; returns at the negedge just after
   // the action has been applied (third rising edge after the press).
   task automatic press(input logic [3:0] m);
      @(negedge clk);
      {btn_mode, btn_next, btn_up, btn_down} = m;
      @(negedge clk);
      {btn_mode, btn_next, btn_up, btn_down} = 4'b0000;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset;
      cur_time = {7'd10, 7'd20, 7'd30};
      repeat (3) @(negedge clk);
      n_checks++;
      if (flash !== 3'b000 || display_mode !== 1'b0 || load !== 1'b0 || load_time !== 21'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: flash=%b mode=%b load=%b load_time=%h, required 000 0 0 0",
                  flash, display_mode, load, load_time);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if (out_time !== {7'd10, 7'd20, 7'd30}) begin
         n_fail++;
         $display("FAIL run_track: got %h, required %h", out_time, {7'd10, 7'd20, 7'd30});
      end
      cur_time = {7'd10, 7'd20, 7'd31};
      #1;
      n_checks++;
      if (out_time !== {7'd10, 7'd20, 7'd31}) begin
         n_fail++;
         $display("FAIL run_track_comb: got %h, required %h", out_time, {7'd10, 7'd20, 7'd31});
      end
   endtask

   task automatic test_mode_toggle;
      @(negedge clk);
      btn_mode = 1'b1;
      @(negedge clk);
      btn_mode = 1'b0;
      @(negedge clk);
      n_checks++;
      if (display_mode !== 1'b0) begin
         n_fail++;
         $display("FAIL mode_early: got %b, required 0", display_mode);
      end
      @(negedge clk);
      n_checks++;
      if (display_mode !== 1'b1) begin
         n_fail++;
         $display("FAIL mode_set: got %b, required 1", display_mode);
      end
      press(4'b1000);
      n_checks++;
      if (display_mode !== 1'b0 || flash !== 3'b000) begin
         n_fail++;
         $display("FAIL mode_clear: mode=%b flash=%b, required 0 000", display_mode, flash);
      end
   endtask

   task automatic test_commit;
      cur_time = {7'd23, 7'd59, 7'd59};
      press(4'b0100);
      n_checks++;
      if (flash !== 3'b100 || out_time !== {7'd23, 7'd59, 7'd59}) begin
         n_fail++;
         $display("FAIL enter_hour: flash=%b out=%h, required 100 %h", flash, out_time, {7'd23, 7'd59, 7'd59});
      end
      cur_time = {7'd1, 7'd2, 7'd3};
      press(4'b0010);
      n_checks++;
      if (out_time !== {7'd0, 7'd59, 7'd59}) begin
         n_fail++;
         $display("FAIL hour_wrap_up: got %h, required %h", out_time, {7'd0, 7'd59, 7'd59});
      end
      press(4'b0100);
      n_checks++;
      if (flash !== 3'b010) begin
         n_fail++;
         $display("FAIL flash_min: got %b, required 010", flash);
      end
      press(4'b0010);
      n_checks++;
      if (out_time !== {7'd0, 7'd0, 7'd59}) begin
         n_fail++;
         $display("FAIL min_wrap_up: got %h, required %h", out_time, {7'd0, 7'd0, 7'd59});
      end
      press(4'b0100);
      n_checks++;
      if (flash !== 3'b001) begin
         n_fail++;
         $display("FAIL flash_sec: got %b, required 001", flash);
      end
      press(4'b0001);
      n_checks++;
      if (out_time !== {7'd0, 7'd0, 7'd58}) begin
         n_fail++;
         $display("FAIL sec_down: got %h, required %h", out_time, {7'd0, 7'd0, 7'd58});
      end
      exp_q.push_back({7'd0, 7'd0, 7'd58});
      press(4'b0100);
      n_checks++;
      if (flash !== 3'b000 || out_time !== {7'd1, 7'd2, 7'd3}) begin
         n_fail++;
         $display("FAIL commit_run: flash=%b out=%h, required 000 %h", flash, out_time, {7'd1, 7'd2, 7'd3});
      end
   endtask

   task automatic test_wrap_clamp;
      cur_time = {7'd0, 7'd30, 7'd30};
      press(4'b0100);
      press(4'b0001);
      n_checks++;
      if (out_time !== {7'd23, 7'd30, 7'd30}) begin
         n_fail++;
         $display("FAIL hour_wrap_down: got %h, required %h", out_time, {7'd23, 7'd30, 7'd30});
      end
      press(4'b1000);
      cur_time = {7'd5, 7'd75, 7'd5};
      press(4'b0100);
      press(4'b0100);
      press(4'b0010);
      n_checks++;
      if (out_time !== {7'd5, 7'd0, 7'd5}) begin
         n_fail++;
         $display("FAIL min75_up: got %h, required %h", out_time, {7'd5, 7'd0, 7'd5});
      end
      press(4'b1000);
      press(4'b0100);
      press(4'b0100);
      press(4'b0001);
      n_checks++;
      if (out_time !== {7'd5, 7'd59, 7'd5}) begin
         n_fail++;
         $display("FAIL min75_down: got %h, required %h", out_time, {7'd5, 7'd59, 7'd5});
      end
      press(4'b1000);
   endtask

   task automatic test_auto_repeat;
      cur_time = {7'd1, 7'd5, 7'd9};
      press(4'b0100);
      press(4'b0100);
      // First step three edges after the press, second 8 cycles later,
      // then one every 4 cycles; the hold covers steps up to 20 cycles in.
      btn_up = 1'b1;
      for (int i = 1; i <= 22; i++) begin
         @(negedge clk);
         if (i == 10) begin
            n_checks++;
            if (out_time !== {7'd1, 7'd6, 7'd9}) begin
               n_fail++;
               $display("FAIL repeat_before_delay: got %h, required %h", out_time, {7'd1, 7'd6, 7'd9});
            end
         end
         if (i == 11) begin
            n_checks++;
            if (out_time !== {7'd1, 7'd7, 7'd9}) begin
               n_fail++;
               $display("FAIL repeat_after_delay: got %h, required %h", out_time, {7'd1, 7'd7, 7'd9});
            end
         end
      end
      btn_up = 1'b0;
      repeat (12) @(negedge clk);
      n_checks++;
      if (out_time !== {7'd1, 7'd10, 7'd9}) begin
         n_fail++;
         $display("FAIL repeat_final: got %h, required %h", out_time, {7'd1, 7'd10, 7'd9});
      end
      press(4'b1000);
   endtask

   task automatic test_abort_timeout;
      press(4'b1000);
      cur_time = {7'd2, 7'd3, 7'd4};
      press(4'b0100);
      press(4'b0100);
      press(4'b1000);
      n_checks++;
      if (flash !== 3'b000 || display_mode !== 1'b1 || out_time !== {7'd2, 7'd3, 7'd4}) begin
         n_fail++;
         $display("FAIL abort: flash=%b mode=%b out=%h, required 000 1 %h",
                  flash, display_mode, out_time, {7'd2, 7'd3, 7'd4});
      end
      press(4'b0100);
      press(4'b0100);
      press(4'b0100);
      repeat (60) @(negedge clk);
      n_checks++;
      if (flash !== 3'b001) begin
         n_fail++;
         $display("FAIL timeout_early: flash=%b, required 001", flash);
      end
      repeat (8) @(negedge clk);
      n_checks++;
      if (flash !== 3'b000 || out_time !== {7'd2, 7'd3, 7'd4}) begin
         n_fail++;
         $display("FAIL timeout: flash=%b out=%h, required 000 %h", flash, out_time, {7'd2, 7'd3, 7'd4});
      end
   endtask

   task automatic test_priority_reset;
      cur_time = {7'd12, 7'd34, 7'd56};
      press(4'b0100);
      press(4'b0011);
      n_checks++;
      if (out_time !== {7'd12, 7'd34, 7'd56} || flash !== 3'b100) begin
         n_fail++;
         $display("FAIL up_down_both: out=%h flash=%b, required %h 100", out_time, flash, {7'd12, 7'd34, 7'd56});
      end
      press(4'b0110);
      n_checks++;
      if (out_time !== {7'd12, 7'd34, 7'd56} || flash !== 3'b010) begin
         n_fail++;
         $display("FAIL next_over_up: out=%h flash=%b, required %h 010", out_time, flash, {7'd12, 7'd34, 7'd56});
      end
      press(4'b0010);
      n_checks++;
      if (out_time !== {7'd12, 7'd35, 7'd56}) begin
         n_fail++;
         $display("FAIL min_up: got %h, required %h", out_time, {7'd12, 7'd35, 7'd56});
      end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (flash !== 3'b000 || display_mode !== 1'b0 || load !== 1'b0 ||
          load_time !== 21'd0 || out_time !== {7'd12, 7'd34, 7'd56}) begin
         n_fail++;
         $display("FAIL reset_mid_edit: flash=%b mode=%b load=%b load_time=%h out=%h, required 000 0 0 0 %h",
                  flash, display_mode, load, load_time, out_time, {7'd12, 7'd34, 7'd56});
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      n_checks++;
      if (flash !== 3'b000 || out_time !== {7'd12, 7'd34, 7'd56}) begin
         n_fail++;
         $display("FAIL after_reset: flash=%b out=%h, required 000 %h", flash, out_time, {7'd12, 7'd34, 7'd56});
      end
   endtask

   initial begin
      test_reset();
      test_mode_toggle();
      test_commit();
      test_wrap_clamp();
      test_auto_repeat();
      test_abort_timeout();
      test_priority_reset();
      repeat (4) @(negedge clk);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL missing_load: %0d queued commits, required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/time_set_controller.md
Name: time_set_controller

Overview:
- Sequences the clock display path: chooses between live time and an edit buffer, and drives the 3-bit field-flash vector and the 12/24-hour display mode.
- Runs the user time-setting state machine from four push buttons, with auto-repeat and inactivity timeout.
- Issues a one-cycle load strobe to the time counter when an edit is committed.
- Sits between the button inputs / time counter and the display controller.

Parameters:
- REPEAT_DELAY, 25000000: cycles btn_up/btn_down must stay high before auto-repeat starts.
- REPEAT_RATE, 5000000: cycles between auto-repeat steps.
- TIMEOUT, 500000000: idle cycles in any SET state before the edit is aborted.
- CNT_W, 32: width of the repeat and timeout counters.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- btn_mode  in  1  raw level; toggles 12/24 mode in RUN, aborts an edit in SET states
- btn_next  in  1  raw level; enters edit mode, advances field, commits the edit
- btn_up  in  1  raw level; increments the selected field
- btn_down  in  1  raw level; decrements the selected field
- cur_time  in  21  live time {hour[20:14], min[13:7], sec[6:0]}, binary
- out_time  out  21  time shown on the display
- flash  out  3  blink enable per field; [2]=hour, [1]=min, [0]=sec
- display_mode  out  1  0 = 24-hour, 1 = 12-hour
- load  out  1  one-cycle commit strobe
- load_time  out  21  value to load into the time counter; valid while load=1

Behaviour:
- Reset (async, rst_n=0):
  - state = RUN; flash = 000; display_mode = 0; load = 0.
  - load_time = 0; edit buffer = 0; all counters = 0; synchronizers = 0.
- Input conditioning:
  - Each button passes through a 2-FF synchronizer, then rising-edge detection.
  - An action takes effect on the 3rd rising clk edge after the raw input rises.
- Button priority, same cycle: mode > next > up/down.
  - Up and down together means no change.
- States and outputs:
  - RUN: out_time = cur_time (combinational), flash = 000.
  - SET_HOUR: out_time = edit, flash = 100.
  - SET_MIN: out_time = edit, flash = 010.
  - SET_SEC: out_time = edit, flash = 001.
  - flash, display_mode, load and load_time are registered.
- RUN transitions:
  - mode edge toggles display_mode.
  - next edge copies cur_time into edit and goes to SET_HOUR.
- SET_* transitions:
  - next goes HOUR -> MIN -> SEC.
  - next in SET_SEC: load = 1 for exactly one cycle, load_time = edit, go to RUN.
  - mode edge aborts: go to RUN, no load, display_mode unchanged.
- Field arithmetic (hour max M = 24, min/sec M = 60):
  - up: v >= M-1 gives 0, otherwise v+1.
  - down: v = 0 or v > M-1 gives M-1, otherwise v-1.
  - Only the selected 7-bit field changes; the other fields hold.
- Auto-repeat:
  - While the synchronized up (or down) level stays high, with the other released, the repeat counter counts.
  - First step on the edge; a second step after REPEAT_DELAY cycles; then one step every REPEAT_RATE cycles.
  - Release, a state change, or both buttons high clears the counter.
- Timeout:
  - The counter clears on any button edge or state change and increments each cycle in SET_*.
  - Reaching TIMEOUT acts like an abort: go to RUN, no load.
- cur_time changes during an edit do not affect edit.
- Reset mid-edit discards edit; no load is issued.

Test Plan (REPEAT_DELAY=8, REPEAT_RATE=4, TIMEOUT=64):
- Reset, then cur_time = {7'd10, 7'd20, 7'd30}:
  - out_time tracks cur_time, flash = 000, display_mode = 0.
  - A btn_mode pulse sets display_mode = 1 three cycles later; a second pulse clears it.
- Commit path, cur_time = {23, 59, 59}:
  - Key sequence: next, up (hour -> 0), next, up (min -> 0), next, down (sec -> 58), next.
  - flash goes 100 -> 010 -> 001 -> 000.
  - load pulses for one cycle with load_time = {0, 0, 58}.
- Wrap and clamp:
  - Edit hour 0 with down gives 23.
  - Captured min = 7'd75: up gives 0, down gives 59.
- Auto-repeat: hold btn_up for 20 cycles after sync in SET_MIN from 5 -> minute = 5+1+1+3 = 10; release stops stepping.
- Abort and timeout:
  - btn_mode in SET_MIN returns to RUN with no load and display_mode unchanged.
  - Idling 64 cycles in SET_SEC returns to RUN with no load.
- Priority and reset:
  - up and down pressed together: no change.
  - next and up pressed together: field advances, value unchanged.
  - rst_n low mid-edit: all outputs return to reset values immediately, with no load.
